// File: rtl/mss_gpio_led_fader.sv
`default_nettype none
// ============================================================================
//  Module      : mss_gpio_led_fader
//  Description : Converts each MSS GPIO_M2F level into a soft-fading PWM LED
//                drive. A high GPIO ramps its LED up to full brightness and a
//                low GPIO ramps it back down to off. Nothing lights until
//                MSS_READY has been seen high through the synchroniser.
//
//  Ports       : CLK_BASE   - fabric clock (FAB_CCC_GL0)
//                RESET      - asynchronous, active-high reset
//                MSS_READY  - MSS ready flag, asynchronous to CLK_BASE
//                GPIO_M2F   - MSS GPIO levels, asynchronous to CLK_BASE
//                LED_OUT    - registered PWM LED drive, active high
//                RAMP_BUSY  - channel is ramping up or down (registered)
//
//  Parameters  : NUM_CH   - number of GPIO/LED channels
//                STEP     - duty change per ramp tick (1..255)
//                RAMP_DIV - PWM periods per ramp tick (1..65535)
//
//  Build macro : GPIO_LED_GAMMA_EN - when defined, the PWM compare uses
//                (duty*duty)>>8 for a perceptually linear fade. When it is
//                undefined the duty is compared directly and no multiplier
//                exists.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mss_gpio_led_fader #(
    parameter int NUM_CH   = 8,
    parameter int STEP     = 16,
    parameter int RAMP_DIV = 4
) (
    input  logic              CLK_BASE,
    input  logic              RESET,
    input  logic              MSS_READY,
    input  logic [NUM_CH-1:0] GPIO_M2F,
    output logic [NUM_CH-1:0] LED_OUT,
    output logic [NUM_CH-1:0] RAMP_BUSY
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [8:0]  c_STEP_W9  = 9'(STEP);
    localparam logic [7:0]  c_STEP_W8  = 8'(STEP);
    localparam logic [15:0] c_DIV_LAST = 16'(RAMP_DIV - 1);
    localparam logic [7:0]  c_DUTY_MAX = 8'hFF;
    localparam logic [7:0]  c_DUTY_MIN = 8'h00;
    localparam logic [7:0]  c_PWM_LAST = 8'hFF;

    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_ON        = 2'd2,
        S_RAMP_DOWN = 2'd3
    } fade_state_t;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous MSS signals
    // ------------------------------------------------------------------------
    logic [NUM_CH-1:0] r_gpio_meta;
    logic [NUM_CH-1:0] r_gpio_sync;
    logic              r_ready_meta;
    logic              r_ready_sync;

    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            r_gpio_meta  <= '0;
            r_gpio_sync  <= '0;
            r_ready_meta <= 1'b0;
            r_ready_sync <= 1'b0;
        end else begin
            r_gpio_meta  <= GPIO_M2F;
            r_gpio_sync  <= r_gpio_meta;
            r_ready_meta <= MSS_READY;
            r_ready_sync <= r_ready_meta;
        end
    end

    // A channel only requests light while the MSS reports ready; dropping
    // READY therefore makes every channel fade out rather than cut hard.
    logic [NUM_CH-1:0] w_req;
    assign w_req = r_gpio_sync & {NUM_CH{r_ready_sync}};

    // ------------------------------------------------------------------------
    // Free-running PWM counter and ramp tick generator
    // ------------------------------------------------------------------------
    logic [7:0]  r_pwm_cnt;
    logic [15:0] r_period_cnt;
    logic        w_pwm_wrap;
    logic        w_tick;

    assign w_pwm_wrap = (r_pwm_cnt == c_PWM_LAST);
    // Tick lands on the last count of a period, so a duty written on the tick
    // is first used at pwm_cnt == 0 of the following period.
    assign w_tick     = w_pwm_wrap && (r_period_cnt == c_DIV_LAST);

    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            r_pwm_cnt    <= '0;
            r_period_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_pwm_wrap) begin
                if (w_tick) begin
                    r_period_cnt <= '0;
                end else begin
                    r_period_cnt <= r_period_cnt + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel fade FSM, duty register and PWM output
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            fade_state_t r_state;
            logic [7:0]  r_duty;
            logic        r_busy;
            logic        r_led;
            logic [8:0]  w_duty_sum;
            logic [7:0]  w_duty_up;
            logic [7:0]  w_duty_dn;
            logic [7:0]  w_eff_duty;

            // Saturating step in both directions; the ninth bit of the sum
            // flags an overflow past full brightness.
            assign w_duty_sum = {1'b0, r_duty} + c_STEP_W9;
            assign w_duty_up  = w_duty_sum[8] ? c_DUTY_MAX : w_duty_sum[7:0];
            assign w_duty_dn  = (r_duty > c_STEP_W8) ? (r_duty - c_STEP_W8)
                                                     : c_DUTY_MIN;

`ifdef GPIO_LED_GAMMA_EN
            // Square-law brightness curve: upper byte of duty*duty, with full
            // duty pinned to full scale.
            assign w_eff_duty = (r_duty == c_DUTY_MAX) ? c_DUTY_MAX
                              : 8'((16'(r_duty) * 16'(r_duty)) >> 8);
`else
            assign w_eff_duty = r_duty;
`endif

            // RAMP_BUSY is loaded together with the state it reflects, so it
            // follows the state register with no extra delay.
            always_ff @(posedge CLK_BASE or posedge RESET) begin
                if (RESET) begin
                    r_state <= S_OFF;
                    r_duty  <= c_DUTY_MIN;
                    r_busy  <= 1'b0;
                end else begin
                    case (r_state)
                        S_OFF: begin
                            if (w_req[i]) begin
                                r_state <= S_RAMP_UP;
                                r_busy  <= 1'b1;
                            end
                        end
                        S_RAMP_UP: begin
                            // A request change outranks a coincident tick:
                            // the direction flips and the duty holds.
                            if (!w_req[i]) begin
                                r_state <= S_RAMP_DOWN;
                                r_busy  <= 1'b1;
                            end else if (w_tick) begin
                                r_duty <= w_duty_up;
                                if (w_duty_up == c_DUTY_MAX) begin
                                    r_state <= S_ON;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end
                        S_ON: begin
                            if (!w_req[i]) begin
                                r_state <= S_RAMP_DOWN;
                                r_busy  <= 1'b1;
                            end
                        end
                        S_RAMP_DOWN: begin
                            if (w_req[i]) begin
                                r_state <= S_RAMP_UP;
                                r_busy  <= 1'b1;
                            end else if (w_tick) begin
                                r_duty <= w_duty_dn;
                                if (w_duty_dn == c_DUTY_MIN) begin
                                    r_state <= S_OFF;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            r_state <= S_OFF;
                            r_duty  <= c_DUTY_MIN;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end

            // Full and zero duty are forced so the LED never shows a one-count
            // sliver of the opposite level.
            always_ff @(posedge CLK_BASE or posedge RESET) begin
                if (RESET) begin
                    r_led <= 1'b0;
                end else if (r_duty == c_DUTY_MAX) begin
                    r_led <= 1'b1;
                end else if (r_duty == c_DUTY_MIN) begin
                    r_led <= 1'b0;
                end else begin
                    r_led <= (r_pwm_cnt < w_eff_duty);
                end
            end

            assign LED_OUT[i]   = r_led;
            assign RAMP_BUSY[i] = r_busy;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mss_gpio_led_fader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mss_gpio_led_fader
//  Description : Self-checking bench for mss_gpio_led_fader. A behavioural
//                model (request delay line, period arithmetic, per-channel
//                brightness level) predicts LED_OUT and RAMP_BUSY each cycle;
//                directed scenarios add hand-computed duty-cycle counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mss_gpio_led_fader;

    localparam int NUM_CH   = 8;
    localparam int STEP     = 64;
    localparam int RAMP_DIV = 1;
    localparam int PERIOD   = 256;

    localparam int M_OFF  = 0;
    localparam int M_UP   = 1;
    localparam int M_ON   = 2;
    localparam int M_DOWN = 3;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              ready = 1'b0;
    logic [NUM_CH-1:0] gpio  = '0;
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] busy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    mss_gpio_led_fader #(
        .NUM_CH   (NUM_CH),
        .STEP     (STEP),
        .RAMP_DIV (RAMP_DIV)
    ) dut (
        .CLK_BASE  (clk),
        .RESET     (rst),
        .MSS_READY (ready),
        .GPIO_M2F  (gpio),
        .LED_OUT   (led),
        .RAMP_BUSY (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Brightness actually compared against the PWM count for a given duty.
    function automatic int eff(input int d);
`ifdef GPIO_LED_GAMMA_EN
        if (d == 255) return 255;
        return (d * d) / 256;
`else
        return d;
`endif
    endfunction

    // LED-high cycles in one 256-cycle period for a given duty.
    function automatic int exp_cnt(input int d);
        if (d >= 255) return PERIOD;
        if (d <= 0)   return 0;
        return eff(d);
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model
    //   edges : clock edges since reset release (edge k uses pwm = k % 256)
    //   req   : request seen at edge k is the input applied before edge k-2
    // ------------------------------------------------------------------------
    int                edges;
    int                m_mode [NUM_CH];
    int                m_duty [NUM_CH];
    logic [NUM_CH-1:0] req_q [$];
    logic [NUM_CH-1:0] m_req;
    logic [NUM_CH-1:0] exp_led  = '0;
    logic [NUM_CH-1:0] exp_busy = '0;
    bit                m_tick;
    int                m_pwm;
    int                m_nd;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            edges = 0;
            req_q.delete();
            req_q.push_back('0);
            req_q.push_back('0);
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = M_OFF;
                m_duty[c] = 0;
            end
            exp_led  = '0;
            exp_busy = '0;
        end else begin
            m_req  = req_q.pop_front();
            req_q.push_back(gpio & {NUM_CH{ready}});
            m_pwm  = edges % PERIOD;
            m_tick = ((edges % (PERIOD * RAMP_DIV)) == PERIOD * RAMP_DIV - 1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_duty[c] == 255)    exp_led[c] = 1'b1;
                else if (m_duty[c] == 0) exp_led[c] = 1'b0;
                else                     exp_led[c] = (m_pwm < eff(m_duty[c]));
                case (m_mode[c])
                    M_OFF: if (m_req[c]) m_mode[c] = M_UP;
                    M_UP: begin
                        if (!m_req[c]) m_mode[c] = M_DOWN;
                        else if (m_tick) begin
                            m_nd = m_duty[c] + STEP;
                            m_duty[c] = (m_nd > 255) ? 255 : m_nd;
                            if (m_duty[c] == 255) m_mode[c] = M_ON;
                        end
                    end
                    M_ON: if (!m_req[c]) m_mode[c] = M_DOWN;
                    default: begin
                        if (m_req[c]) m_mode[c] = M_UP;
                        else if (m_tick) begin
                            m_nd = m_duty[c] - STEP;
                            m_duty[c] = (m_nd < 0) ? 0 : m_nd;
                            if (m_duty[c] == 0) m_mode[c] = M_OFF;
                        end
                    end
                endcase
                exp_busy[c] = (m_mode[c] == M_UP) || (m_mode[c] == M_DOWN);
            end
            edges++;
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("led_vs_model",  32'(led),  32'(exp_led));
            check("busy_vs_model", 32'(busy), 32'(exp_busy));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus tasks (all return aligned to a falling edge)
    // ------------------------------------------------------------------------
    int hi [NUM_CH];

    task automatic do_reset(input logic [NUM_CH-1:0] g, input logic r);
        @(negedge clk);
        rst   = 1'b1;
        gpio  = g;
        ready = r;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        int guard;
        guard = 0;
        while (edges != n) begin
            @(negedge clk);
            guard++;
            if (guard > 5000) begin
                check("wait_edges_timeout", 32'(edges), 32'(n));
                return;
            end
        end
    endtask

    // Count LED-high cycles for every channel over the period starting at
    // edge start_k.
    task automatic count_period(input int start_k);
        for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
        wait_edges(start_k + 1);
        for (int j = 0; j < PERIOD; j++) begin
            for (int c = 0; c < NUM_CH; c++) if (led[c]) hi[c]++;
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    int nz_led;
    int nz_busy;
    int sel;
    int guard;

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Idle: GPIO low, READY high -> dark and idle
        do_reset('0, 1'b1);
        check("reset_led",  32'(led),  32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        nz_led = 0; nz_busy = 0;
        repeat (2000) begin
            @(negedge clk);
            if (led  != 0) nz_led++;
            if (busy != 0) nz_busy++;
        end
        check("idle_led_cycles",  32'(nz_led),  32'h0);
        check("idle_busy_cycles", 32'(nz_busy), 32'h0);

        // READY low gates all requests
        ready = 1'b0;
        gpio  = 8'hFF;
        nz_led = 0; nz_busy = 0;
        repeat (600) begin
            @(negedge clk);
            if (led  != 0) nz_led++;
            if (busy != 0) nz_busy++;
        end
        check("notready_led_cycles",  32'(nz_led),  32'h0);
        check("notready_busy_cycles", 32'(nz_busy), 32'h0);
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_busy_at_2", 32'(busy), 32'h00);
        @(negedge clk);
        check("ready_busy_at_3", 32'(busy), 32'hFF);

        // Ramp-up on ch0 and reversal on ch3
        do_reset(8'h09, 1'b1);
        fork
            begin
                count_period(256);
                check("ch0_p1_high", 32'(hi[0]), 32'(exp_cnt(64)));
                check("ch3_p1_high", 32'(hi[3]), 32'(exp_cnt(64)));
                count_period(512);
                check("ch0_p2_high", 32'(hi[0]), 32'(exp_cnt(128)));
                check("ch3_p2_high", 32'(hi[3]), 32'(exp_cnt(128)));
                count_period(768);
                check("ch0_p3_high", 32'(hi[0]), 32'(exp_cnt(192)));
                check("ch3_p3_high", 32'(hi[3]), 32'(exp_cnt(64)));
                count_period(1024);
                check("ch0_p4_high", 32'(hi[0]), 32'(PERIOD));
                check("ch3_p4_high", 32'(hi[3]), 32'h0);
                check("ramp_done_busy", 32'(busy), 32'h0);
                check("ch1_p4_high", 32'(hi[1]), 32'h0);
            end
            begin
                wait_edges(601);
                gpio[3] = 1'b0;
            end
        join

        // Asynchronous reset mid-ramp (ch0 at duty 192)
        do_reset(8'h01, 1'b1);
        wait_edges(901);
        check("pre_rst_led0",  32'(led[0]),  32'h1);
        check("pre_rst_busy0", 32'(busy[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led",  32'(led),  32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_edges(2);
        check("restart_busy_at_2", 32'(busy), 32'h00);
        @(negedge clk);
        check("restart_busy_at_3", 32'(busy), 32'h01);
        count_period(256);
        check("restart_p1_high", 32'(hi[0]), 32'(exp_cnt(64)));

        // Randomised GPIO / READY activity, some aimed at tick edges
        do_reset('0, 1'b1);
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                ready = ~ready;
            end else if (sel == 1) begin
                gpio = 8'($urandom);
            end else if (sel == 2) begin
                // Request change that reaches the FSM on a tick edge
                guard = 0;
                while ((edges % PERIOD) != 253 && guard < 600) begin
                    @(negedge clk);
                    guard++;
                end
                gpio = gpio ^ 8'($urandom);
            end else begin
                gpio = gpio ^ (8'd1 << $urandom_range(0, 7));
            end
            if (n == 20) do_reset(gpio, ready);
            repeat ($urandom_range(1, 700)) @(negedge clk);
        end
        gpio = '0;
        repeat (1200) @(negedge clk);
        check("final_led_dark", 32'(led), 32'h0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
